break_select_sequencer: RTL
===========================

Name: break_select_sequencer

Overview:
- Controller that drives the break-value counter/heuristic-selector stage for one flip decision.
- Accepts up to NSAT candidate variables from a chosen unsatisfied clause.
- For each candidate, fetches that variable's clause-broken and mask vectors from the per-variable clause memory, then presents them with the wren sequence idle → one-hot → all-ones.
- Samples the selector's choice, collects the selected variable's clause-broken bits, and hands the flip result downstream with a valid/ready handshake.

Parameters:
- NSAT, 3, literals per clause / candidates per decision.
- NSAT_BITS, 2, wren/select width; must equal NSAT-1.
- NUM_CLAUSES, 20, width of the clause-broken and mask vectors (max clauses per variable).
- VAR_BITS, 8, variable index width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start_i  in  1  request valid.
- start_ready_o  out  1  high only in IDLE.
- cand_vars_i  in  NSAT*VAR_BITS  candidate k at [k*VAR_BITS +: VAR_BITS].
- cand_valid_i  in  NSAT  per-slot valid.
- rd_en_o  out  1  clause-memory read strobe.
- rd_addr_o  out  VAR_BITS  variable index.
- rd_data_i  in  2*NUM_CLAUSES  [NUM_CLAUSES-1:0] broken, upper half mask; valid exactly 1 cycle after rd_en_o.
- clause_broken_o  out  NUM_CLAUSES  to counter.
- mask_bits_o  out  NUM_CLAUSES  to counter.
- break_values_valid_o  out  NSAT  latched cand_valid.
- wren_o  out  NSAT_BITS  counter/selector control.
- select_i  in  NSAT_BITS  selector choice.
- clause_broken_bits_i  in  NUM_CLAUSES  selected variable's broken bits.
- flip_valid_o  out  1  result valid.
- flip_ready_i  in  1  consumer ready.
- flip_var_o  out  VAR_BITS  variable to flip.
- flip_broken_bits_o  out  NUM_CLAUSES  its clause-broken bits.
- no_candidate_o  out  1  all slots invalid.

Behaviour:
- Reset: all outputs 0 except start_ready_o=1; state IDLE; latched candidates cleared. reset_n low mid-operation aborts immediately to IDLE; no partial result is ever emitted.
- Acceptance: start_i && start_ready_o at an edge latches cand_vars_i and cand_valid_i.
- If latched cand_valid == 0: go directly to DONE with no_candidate_o=1, flip_var_o=0, flip_broken_bits_o=0; no reads and no wren activity.
- Otherwise, states in order: RD0, LD0, RD1, LD1, ..., RD(NSAT-1), LD(NSAT-1), SEL, CAP, BITS, DONE.
- RDk: rd_en_o=1, rd_addr_o=var[k]. If cand_valid[k]=0, rd_en_o stays 0 and the slot's data is treated as all zeros.
- LDk: rd_data_i is valid. On exiting LDk, clause_broken_o and mask_bits_o are registered from rd_data_i (zeros for an invalid slot).
  - k < NSAT-1: wren_o ← one-hot bit k.
  - k = NSAT-1: wren_o ← all ones.
  - wren_o is nonzero for exactly one cycle per slot and is 0 during every LD state.
  - clause_broken_o and mask_bits_o are stable through each wren cycle.
- SEL: wren_o = all ones; break_values_valid_o = latched cand_valid. break_values_valid_o is 0 in all other states.
- CAP: wren_o = 0; register sel ← select_i.
- BITS: register flip_broken_bits_o ← clause_broken_bits_i; flip_var_o ← var[sel].
- DONE: flip_valid_o=1. Result outputs are held stable until flip_ready_i. The handshake edge returns the block to IDLE and clears flip_valid_o and no_candidate_o.
- start_ready_o=0 outside IDLE; start_i while busy is ignored, with no queueing.
- Latency with zero backpressure: flip_valid_o rises 3*NSAT+3 edges after the accepting edge (12 for NSAT=3); it rises 1 edge after acceptance for the no-candidate case.
- Minimum repeat interval: one IDLE cycle between requests.
- select_i ≥ NSAT is out of contract; flip_var_o then takes var[0].

Test Plan:
- Normal run: vars {0x05,0x11,0x2A}, valid=3'b111, memory returns distinct patterns, selector model returns 2 in CAP.
  - Required: rd_addr sequence 05, 11, 2A.
  - Required: wren_o sequence 01, 00, 10, 00, 11, 00.
  - Required: flip_var_o=0x2A, flip_valid_o 12 edges after acceptance.
- Invalid slot: valid=3'b101.
  - Required: no rd_en_o in RD1; clause_broken_o=mask_bits_o=0 during wren=10; break_values_valid_o=101 in SEL.
- All invalid: valid=3'b000.
  - Required: flip_valid_o=1 and no_candidate_o=1 one edge after acceptance; rd_en_o and wren_o never asserted.
- Backpressure: hold flip_ready_i=0 for 5 cycles in DONE.
  - Required: flip_var_o and flip_broken_bits_o stable; start_ready_o=0; return to IDLE on the edge after ready rises.
- Reset mid-op: pull reset_n low asynchronously during LD1.
  - Required: all outputs 0 immediately, start_ready_o=1 after release, no flip_valid_o.
- Start while busy: pulse start_i during SEL.
  - Required: ignored; the in-flight result is unchanged and no second run follows.

Source files
------------

// File: rtl/break_select_sequencer_if.sv
// Bundle of request, clause-memory, counter/selector and flip-result signals
// for break_select_sequencer; slave is the sequencer side, master its environment.
interface break_select_sequencer_if #(
   parameter int unsigned NSAT        = 3,
   parameter int unsigned NSAT_BITS   = 2,
   parameter int unsigned NUM_CLAUSES = 20,
   parameter int unsigned VAR_BITS    = 8
);
   logic                       start_i;
   logic                       start_ready_o;
   logic [NSAT*VAR_BITS-1:0]   cand_vars_i;
   logic [NSAT-1:0]            cand_valid_i;
   logic                       rd_en_o;
   logic [VAR_BITS-1:0]        rd_addr_o;
   logic [2*NUM_CLAUSES-1:0]   rd_data_i;
   logic [NUM_CLAUSES-1:0]     clause_broken_o;
   logic [NUM_CLAUSES-1:0]     mask_bits_o;
   logic [NSAT-1:0]            break_values_valid_o;
   logic [NSAT_BITS-1:0]       wren_o;
   logic [NSAT_BITS-1:0]       select_i;
   logic [NUM_CLAUSES-1:0]     clause_broken_bits_i;
   logic                       flip_valid_o;
   logic                       flip_ready_i;
   logic [VAR_BITS-1:0]        flip_var_o;
   logic [NUM_CLAUSES-1:0]     flip_broken_bits_o;
   logic                       no_candidate_o;

   modport slave (
      input  start_i, cand_vars_i, cand_valid_i, rd_data_i, select_i,
             clause_broken_bits_i, flip_ready_i,
      output start_ready_o, rd_en_o, rd_addr_o, clause_broken_o, mask_bits_o,
             break_values_valid_o, wren_o, flip_valid_o, flip_var_o,
             flip_broken_bits_o, no_candidate_o
   );

   modport master (
      output start_i, cand_vars_i, cand_valid_i, rd_data_i, select_i,
             clause_broken_bits_i, flip_ready_i,
      input  start_ready_o, rd_en_o, rd_addr_o, clause_broken_o, mask_bits_o,
             break_values_valid_o, wren_o, flip_valid_o, flip_var_o,
             flip_broken_bits_o, no_candidate_o
   );
endinterface

// File: rtl/break_select_sequencer.sv
// Sequences clause-memory reads and counter wren strobes for one flip decision,
// then captures the selector's choice and offers it on a valid/ready handshake.
module break_select_sequencer #(
   parameter int unsigned NSAT        = 3,
   parameter int unsigned NSAT_BITS   = 2,
   parameter int unsigned NUM_CLAUSES = 20,
   parameter int unsigned VAR_BITS    = 8
) (
   input logic                     clk,
   input logic                     reset_n,
   break_select_sequencer_if.slave bus
);
   localparam int unsigned KW = (NSAT > 1) ? $clog2(NSAT) : 1;
   localparam logic [KW-1:0] LAST_SLOT = KW'(NSAT - 1);

   // CHK is the cycle after acceptance that routes an empty request straight to DONE;
   // WR carries the one-hot wren strobe, the final all-ones strobe is SEL itself.
   typedef enum logic [3:0] {IDLE, CHK, RD, LD, WR, SEL, CAP, BITS, DONE} state_t;

   state_t                 state_q, state_d;
   logic [KW-1:0]          slot_q, slot_d;
   logic [VAR_BITS-1:0]    var_q [NSAT];
   logic [NSAT-1:0]        valid_q;
   logic [NSAT_BITS-1:0]   sel_q;
   logic [KW-1:0]          sel_idx;
   logic [NUM_CLAUSES-1:0] broken_q, mask_q, flip_bits_q;
   logic [VAR_BITS-1:0]    flip_var_q;
   logic                   no_cand_q;
   logic                   accept;
   logic [NSAT_BITS-1:0]   wren;

   assign accept = (state_q == IDLE) && bus.start_i;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         slot_q  <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
      end
   end

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      case (state_q)
         IDLE: if (bus.start_i) state_d = CHK;
         CHK: begin
            slot_d  = '0;
            state_d = (valid_q == '0) ? DONE : RD;
         end
         RD:   state_d = LD;
         LD:   state_d = (slot_q == LAST_SLOT) ? SEL : WR;
         WR: begin
            slot_d  = slot_q + KW'(1);
            state_d = RD;
         end
         SEL:  state_d = CAP;
         CAP:  state_d = BITS;
         BITS: state_d = DONE;
         DONE: if (bus.flip_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Out-of-range selector choices fall back to candidate 0.
   always_comb begin
      sel_idx = '0;
      if (32'(sel_q) < NSAT) sel_idx = KW'(sel_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NSAT; i++) var_q[i] <= '0;
         valid_q     <= '0;
         sel_q       <= '0;
         broken_q    <= '0;
         mask_q      <= '0;
         flip_bits_q <= '0;
         flip_var_q  <= '0;
         no_cand_q   <= 1'b0;
      end else begin
         if (accept) begin
            for (int unsigned i = 0; i < NSAT; i++)
               var_q[i] <= bus.cand_vars_i[i*VAR_BITS +: VAR_BITS];
            valid_q <= bus.cand_valid_i;
         end
         if (state_q == CHK && valid_q == '0) begin
            no_cand_q   <= 1'b1;
            flip_var_q  <= '0;
            flip_bits_q <= '0;
         end
         if (state_q == LD) begin
            broken_q <= valid_q[slot_q] ? bus.rd_data_i[NUM_CLAUSES-1:0] : '0;
            mask_q   <= valid_q[slot_q] ? bus.rd_data_i[2*NUM_CLAUSES-1:NUM_CLAUSES] : '0;
         end
         if (state_q == CAP) sel_q <= bus.select_i;
         if (state_q == BITS) begin
            flip_bits_q <= bus.clause_broken_bits_i;
            flip_var_q  <= var_q[sel_idx];
         end
         if (state_q == DONE && bus.flip_ready_i) no_cand_q <= 1'b0;
      end
   end

   always_comb begin
      wren = '0;
      if (state_q == WR)       wren = NSAT_BITS'(1) << slot_q;
      else if (state_q == SEL) wren = '1;
   end

   assign bus.start_ready_o        = (state_q == IDLE);
   assign bus.rd_en_o              = (state_q == RD) && valid_q[slot_q];
   assign bus.rd_addr_o            = (state_q == RD) ? var_q[slot_q] : '0;
   assign bus.clause_broken_o      = broken_q;
   assign bus.mask_bits_o          = mask_q;
   assign bus.break_values_valid_o = (state_q == SEL) ? valid_q : '0;
   assign bus.wren_o               = wren;
   assign bus.flip_valid_o         = (state_q == DONE);
   assign bus.flip_var_o           = flip_var_q;
   assign bus.flip_broken_bits_o   = flip_bits_q;
   assign bus.no_candidate_o       = no_cand_q;
endmodule
